// File: rtl/fp_wb_if.sv
// Bundle of issue, execute-stage and writeback signals around the FP
// writeback controller. The slave modport is the controller's view; the
// master modport is the view of everything around it.
interface fp_wb_if;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_to_int;
    logic        issue_ready;
    logic        busy;
    logic        exe_enable;
    logic        exe_ready;
    logic [31:0] exe_result;
    logic [4:0]  exe_flags;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_to_int;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic        timeout;

    modport master (
        output issue_valid, issue_rd, issue_to_int,
        output exe_ready, exe_result, exe_flags,
        output wb_ready, fflags_clr,
        input  issue_ready, busy, exe_enable,
        input  wb_valid, wb_rd, wb_data, wb_to_int,
        input  fflags, timeout
    );

    modport slave (
        input  issue_valid, issue_rd, issue_to_int,
        input  exe_ready, exe_result, exe_flags,
        input  wb_ready, fflags_clr,
        output issue_ready, busy, exe_enable,
        output wb_valid, wb_rd, wb_data, wb_to_int,
        output fflags, timeout
    );
endinterface

// File: rtl/fp_wb_ctrl.sv
// FP execute sequencing and writeback controller: runs one op at a time
// through the execute stage, guards it with a watchdog, queues completed
// results in a small FIFO toward the register file and accrues sticky fflags.
module fp_wb_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic   clk,
    input  logic   rst_n,
    fp_wb_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   wdog;
    logic [4:0]      op_rd;
    logic            op_to_int;

    logic [4:0]      mem_rd     [DEPTH];
    logic            mem_to_int [DEPTH];
    logic [31:0]     mem_data   [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic [4:0]      fflags_q;
    logic            timeout_q;

    logic            in_exec, done, room, issue_rdy, accept, abort, push, pop, fifo_nonempty;

    assign in_exec       = (state == S_EXEC);
    assign done          = in_exec & bus.exe_ready;
    // Room is judged before any pop, so a completing op always finds a free slot.
    assign room          = ({1'b0, count} + (CW+1)'(done)) < (CW+1)'(DEPTH);
    assign issue_rdy     = (~in_exec | done) & room;
    assign accept        = bus.issue_valid & issue_rdy;
    assign abort         = in_exec & ~bus.exe_ready & (wdog == TW'(TIMEOUT - 1));
    assign fifo_nonempty = (count != '0);
    assign push          = done;
    assign pop           = fifo_nonempty & bus.wb_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: stay in EXEC across back-to-back issues, leave on completion or abort.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_EXEC;
            S_EXEC: begin
                if (done)       state_nxt = accept ? S_EXEC : S_IDLE;
                else if (abort) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: enable and busy are straight decodes of the registered state.
    always_comb begin
        bus.exe_enable  = in_exec;
        bus.busy        = in_exec;
        bus.issue_ready = issue_rdy;
    end

    // Watchdog: counts EXEC cycles without ready, restarted by every accepted op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              wdog <= '0;
        else if (accept || abort)                wdog <= '0;
        else if (in_exec && !bus.exe_ready)      wdog <= wdog + 1'b1;
    end

    // Destination of the op in flight, captured on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_rd     <= bus.issue_rd;
            op_to_int <= bus.issue_to_int;
        end
    end

    // FIFO storage: written at the tail when an op completes.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]     <= op_rd;
            mem_to_int[wr_ptr] <= op_to_int;
            mem_data[wr_ptr]   <= bus.exe_result;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a clear coinciding with a completion keeps only the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fflags_q <= '0;
        else if (bus.fflags_clr) fflags_q <= done ? bus.exe_flags : 5'd0;
        else if (done)           fflags_q <= fflags_q | bus.exe_flags;
    end

    // Sticky watchdog indication, only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     timeout_q <= 1'b0;
        else if (abort) timeout_q <= 1'b1;
    end

    // Writeback port shows the head entry, zeros when the FIFO is empty.
    always_comb begin
        bus.wb_valid  = fifo_nonempty;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.wb_to_int = 1'b0;
        if (fifo_nonempty) begin
            bus.wb_rd     = mem_rd[rd_ptr];
            bus.wb_data   = mem_data[rd_ptr];
            bus.wb_to_int = mem_to_int[rd_ptr];
        end
        bus.fflags  = fflags_q;
        bus.timeout = timeout_q;
    end
endmodule

// File: tb/tb_fp_wb_ctrl.sv
// Bench for fp_wb_ctrl: directed scenarios plus a random phase, with an
// execute-stage model and an in-order writeback scoreboard.
module tb_fp_wb_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst_n;
    fp_wb_if bus();

    fp_wb_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          lat;
        logic [31:0] res;
        logic [4:0]  fl;
    } op_t;

    typedef struct {
        logic [4:0]  rd;
        logic        ti;
        logic [31:0] data;
    } wb_t;

    op_t        op_q[$];
    wb_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         wb_mode = 0;
    logic [4:0] fexp = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Offer one op on this cycle; ops that never complete (lat >= TIMEOUT) expect no writeback.
    task automatic try_issue(input logic [4:0] rd, input logic ti, input int lat,
                             input logic [31:0] res, input logic [4:0] fl, output bit acc);
        op_t o;
        wb_t w;
        @(negedge clk);
        bus.issue_valid  = 1'b1;
        bus.issue_rd     = rd;
        bus.issue_to_int = ti;
        #1;
        acc = bus.issue_ready;
        if (acc) begin
            o.lat = lat; o.res = res; o.fl = fl;
            op_q.push_back(o);
            if (lat < TIMEOUT) begin
                w.rd = rd; w.ti = ti; w.data = res;
                exp_q.push_back(w);
                fexp = fexp | fl;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.issue_valid = 1'b0;
        end
    endtask

    // Execute-stage model: each op raises ready after its latency in enabled cycles.
    initial begin
        op_t cur;
        bit  active;
        int  cyc;
        active = 0; cyc = 0;
        cur.lat = 0; cur.res = '0; cur.fl = '0;
        bus.exe_ready  = 1'b0;
        bus.exe_result = '0;
        bus.exe_flags  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                bus.exe_ready = 1'b0;
            end else begin
                if (bus.exe_ready || !bus.exe_enable) active = 0;
                if (bus.exe_enable && !active && op_q.size() > 0) begin
                    cur = op_q.pop_front();
                    active = 1;
                    cyc = 0;
                end
                if (active) begin
                    bus.exe_ready  = (cyc == cur.lat);
                    bus.exe_result = cur.res;
                    bus.exe_flags  = cur.fl;
                    cyc++;
                end else begin
                    bus.exe_ready = 1'b0;
                end
            end
        end
    end

    // Register-file side acceptance: held low, held high, or random.
    initial begin
        bus.wb_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (wb_mode)
                0:       bus.wb_ready = 1'b0;
                1:       bus.wb_ready = 1'b1;
                default: bus.wb_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every accepted writeback must match the oldest expected entry.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus.wb_valid) begin
                    if (bus.wb_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback",
                                     bus.wb_rd, bus.wb_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
                            chk("wb_data", 64'(bus.wb_data), 64'(e.data));
                            chk("wb_to_int", 64'(bus.wb_to_int), 64'(e.ti));
                        end
                    end
                end else begin
                    chk("wb_empty_zero", {26'd0, bus.wb_to_int, bus.wb_rd, bus.wb_data}, 64'd0);
                end
            end
        end
    end

    initial begin
        bit acc;
        int cnt, stall, nacc;
        bus.issue_valid  = 1'b0;
        bus.issue_rd     = '0;
        bus.issue_to_int = 1'b0;
        bus.fflags_clr   = 1'b0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_exe_enable", 64'(bus.exe_enable), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_wb_valid", 64'(bus.wb_valid), 0);
        chk("rst_wb_rd", 64'(bus.wb_rd), 0);
        chk("rst_wb_data", 64'(bus.wb_data), 0);
        chk("rst_wb_to_int", 64'(bus.wb_to_int), 0);
        chk("rst_fflags", 64'(bus.fflags), 0);
        chk("rst_timeout", 64'(bus.timeout), 0);
        chk("rst_issue_ready", 64'(bus.issue_ready), 1);
        #1 rst_n = 1'b1;

        // Single-cycle op latency
        wb_mode = 1;
        try_issue(5'd3, 1'b0, 0, 32'h3F800000, 5'h01, acc);
        chk("t1_accept", 64'(acc), 1);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        #2;
        chk("t1_enable_n1", 64'(bus.exe_enable), 1);
        chk("t1_wbvalid_n1", 64'(bus.wb_valid), 0);
        @(negedge clk);
        #2;
        chk("t1_wbvalid_n2", 64'(bus.wb_valid), 1);
        chk("t1_wb_rd", 64'(bus.wb_rd), 3);
        chk("t1_wb_data", 64'(bus.wb_data), 64'h3F800000);
        chk("t1_fflags", 64'(bus.fflags), 1);
        idle(2);

        // Multi-cycle op
        try_issue(5'd7, 1'b1, 4, 32'h40400000, 5'h04, acc);
        chk("t2_accept", 64'(acc), 1);
        cnt = 0; stall = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.issue_valid = 1'b0;
            #2;
            if (bus.busy) cnt++;
            if (bus.busy && !bus.issue_ready) stall++;
        end
        chk("t2_busy_cycles", 64'(cnt), 5);
        chk("t2_stall_cycles", 64'(stall), 4);
        chk("t2_fflags", 64'(bus.fflags), 5);

        // FIFO backpressure
        wb_mode = 0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            try_issue(5'(10 + i), 1'(i), 0, $urandom, 5'h00, acc);
            if (acc) nacc++;
        end
        idle(3);
        #2;
        chk("t3_accepted", 64'(nacc), 4);
        chk("t3_issue_ready_full", 64'(bus.issue_ready), 0);
        chk("t3_wb_valid_full", 64'(bus.wb_valid), 1);
        wb_mode = 1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        chk("t3_drained", 64'(exp_q.size()), 0);
        nacc = 0;
        for (int i = 0; i < 2; i++) begin
            try_issue(5'(20 + i), 1'b0, 0, $urandom, 5'h00, acc);
            if (acc) nacc++;
        end
        chk("t3_resume", 64'(nacc), 2);
        idle(4);

        // Flag clear colliding with a completion
        @(negedge clk); bus.fflags_clr = 1'b1;
        @(negedge clk); bus.fflags_clr = 1'b0;
        #2;
        chk("t4_clear", 64'(bus.fflags), 0);
        try_issue(5'd1, 1'b0, 0, 32'h11111111, 5'h03, acc);
        idle(3);
        #2;
        chk("t4_fflags_03", 64'(bus.fflags), 3);
        try_issue(5'd2, 1'b0, 0, 32'h22222222, 5'h10, acc);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.fflags_clr  = 1'b1;
        @(negedge clk);
        bus.fflags_clr = 1'b0;
        #2;
        chk("t4_clr_and_done", 64'(bus.fflags), 64'h10);
        idle(3);

        // Watchdog abort
        try_issue(5'd4, 1'b0, 1000, 32'hDEADBEEF, 5'h1F, acc);
        chk("t5_accept", 64'(acc), 1);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.issue_valid = 1'b0;
            #2;
            if (bus.busy) cnt++;
            else break;
        end
        chk("t5_exec_cycles", 64'(cnt), 64'(TIMEOUT));
        chk("t5_timeout", 64'(bus.timeout), 1);
        chk("t5_fflags_kept", 64'(bus.fflags), 64'h10);
        chk("t5_no_push", 64'(bus.wb_valid), 0);
        try_issue(5'd5, 1'b0, 0, 32'h55555555, 5'h00, acc);
        chk("t5_recover", 64'(acc), 1);
        idle(4);

        // Reset in the middle of a multi-cycle op with queued results
        wb_mode = 0;
        nacc = 0;
        try_issue(5'd20, 1'b0, 0, 32'hA0A0A0A0, 5'h00, acc); if (acc) nacc++;
        try_issue(5'd21, 1'b1, 0, 32'hB1B1B1B1, 5'h00, acc); if (acc) nacc++;
        try_issue(5'd22, 1'b0, 10, 32'hC2C2C2C2, 5'h00, acc); if (acc) nacc++;
        chk("t6_accepted", 64'(nacc), 3);
        idle(3);
        #2;
        chk("t6_busy_before", 64'(bus.busy), 1);
        chk("t6_wbvalid_before", 64'(bus.wb_valid), 1);
        #1 rst_n = 1'b0;
        op_q.delete();
        exp_q.delete();
        #1;
        chk("t6_rst_enable", 64'(bus.exe_enable), 0);
        chk("t6_rst_busy", 64'(bus.busy), 0);
        chk("t6_rst_wb", {26'd0, bus.wb_valid, bus.wb_to_int, bus.wb_rd, bus.wb_data}, 64'd0);
        chk("t6_rst_fflags", 64'(bus.fflags), 0);
        chk("t6_rst_timeout", 64'(bus.timeout), 0);
        chk("t6_rst_issue_ready", 64'(bus.issue_ready), 1);
        @(negedge clk);
        #3 rst_n = 1'b1;
        wb_mode = 1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            if (bus.wb_valid) cnt++;
        end
        chk("t6_no_writeback", 64'(cnt), 0);

        // Random traffic
        @(negedge clk); bus.fflags_clr = 1'b1;
        @(negedge clk); bus.fflags_clr = 1'b0;
        fexp = '0;
        wb_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7)
                try_issue(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 4)), $urandom, 5'($urandom_range(0, 31)), acc);
            else
                idle(1);
        end
        wb_mode = 1;
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            idle(1);
            #2;
            if (exp_q.size() == 0 && !bus.busy) break;
            cnt++;
        end
        idle(2);
        #2;
        chk("rand_drained", 64'(exp_q.size()), 0);
        chk("rand_fifo_empty", 64'(bus.wb_valid), 0);
        chk("rand_fflags", 64'(bus.fflags), 64'(fexp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
